// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit -- pipeline control unit fed by the execute stage.
//
// Tracks whether the ID and EX stages hold real instructions, redirects the
// PC on a taken jump (flushing IF/ID and ID/EX for FLUSH_CYCLES cycles),
// stalls on external bus hold requests and on load-use hazards, and gates
// the EX write-back enable.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   ex2cu_jump_en_i      jump/branch-taken request from EX
//   idex2cu_opcode_i     opcode of the instruction in EX
//   idex2cu_rd_addr_i    rd of the instruction in EX
//   ifid2cu_rs1_i/rs2_i  source registers of the instruction in ID
//   bus2cu_hold_req_i    external fetch/memory stall request
//   cu2pc_jump_en_o      PC loads the jump target this cycle
//   cu2pc_hold_o         PC keeps its value
//   cu2ifid_hold_o       IF/ID keeps its contents
//   cu2ifid_flush_o      IF/ID loads a NOP at the next edge
//   cu2idex_flush_o      ID/EX loads a NOP at the next edge
//   cu2ex_wb_en_o        write-back enable for EX
//   cu_busy_o            high while post-jump flushing is in progress
//
// Optional feature (macro CU_PERF_CNT_EN): adds cu_jump_cnt_o and
// cu_stall_cnt_o, counting taken jumps and PC-hold cycles (wrap at 2^32).
// While rst is high every output, counters included, reads as zero.

module pipe_ctrl_unit #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [6:0]  OPC_LOAD     = 7'b0000011,
    parameter logic [6:0]  OPC_STORE    = 7'b0100011,
    parameter logic [6:0]  OPC_BRANCH   = 7'b1100011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ex2cu_jump_en_i,
    input  logic [6:0] idex2cu_opcode_i,
    input  logic [4:0] idex2cu_rd_addr_i,
    input  logic [4:0] ifid2cu_rs1_i,
    input  logic [4:0] ifid2cu_rs2_i,
    input  logic       bus2cu_hold_req_i,
    output logic       cu2pc_jump_en_o,
    output logic       cu2pc_hold_o,
    output logic       cu2ifid_hold_o,
    output logic       cu2ifid_flush_o,
    output logic       cu2idex_flush_o,
    output logic       cu2ex_wb_en_o,
    output logic       cu_busy_o
`ifdef CU_PERF_CNT_EN
    ,
    output logic [31:0] cu_jump_cnt_o,
    output logic [31:0] cu_stall_cnt_o
`endif
);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    localparam logic [2:0] FLUSH_CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t     state;
    logic [2:0] flush_cnt;
    logic       id_valid;
    logic       ex_valid;

    logic       jump_taken;
    logic       load_use;
    logic       stall;
    logic       ifid_flush;
    logic       idex_flush;
    logic       wb_en;

    always_comb begin
        jump_taken = 1'b0;
        load_use   = 1'b0;
        stall      = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        wb_en      = 1'b0;

        if (!rst) begin
            jump_taken = ex2cu_jump_en_i & ex_valid & (state == RUN);

            load_use = ex_valid & id_valid
                     & (idex2cu_opcode_i == OPC_LOAD)
                     & (idex2cu_rd_addr_i != '0)
                     & ((idex2cu_rd_addr_i == ifid2cu_rs1_i) |
                        (idex2cu_rd_addr_i == ifid2cu_rs2_i));

            // Bus hold and load-use share one stall path; both are
            // suppressed by a taken jump or an ongoing flush.
            stall = (state == RUN) & ~jump_taken & (bus2cu_hold_req_i | load_use);

            ifid_flush = jump_taken | (state == FLUSH);
            idex_flush = ifid_flush | stall;

            wb_en = ex_valid
                  & (idex2cu_opcode_i != OPC_STORE)
                  & (idex2cu_opcode_i != OPC_BRANCH)
                  & (idex2cu_opcode_i != '0)
                  & (idex2cu_rd_addr_i != '0);
        end
    end

    assign cu2pc_jump_en_o = jump_taken;
    assign cu2pc_hold_o    = stall;
    assign cu2ifid_hold_o  = stall;
    assign cu2ifid_flush_o = ifid_flush;
    assign cu2idex_flush_o = idex_flush;
    assign cu2ex_wb_en_o   = wb_en;
    assign cu_busy_o       = ~rst & (state == FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= '0;
            id_valid  <= 1'b0;
            ex_valid  <= 1'b0;
        end else begin
            id_valid <= ifid_flush ? 1'b0 : (stall ? id_valid : 1'b1);
            ex_valid <= idex_flush ? 1'b0 : id_valid;

            case (state)
                RUN: begin
                    // The jump cycle itself is the first flush cycle, so
                    // FLUSH only covers the remaining FLUSH_CYCLES-1.
                    if (jump_taken && (FLUSH_CYCLES > 1)) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_CNT_INIT;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 3'd1) begin
                        state     <= RUN;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: begin
                    state     <= RUN;
                    flush_cnt <= '0;
                end
            endcase
        end
    end

`ifdef CU_PERF_CNT_EN
    logic [31:0] jump_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            jump_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (jump_taken) jump_cnt  <= jump_cnt + 32'd1;
            if (stall)      stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign cu_jump_cnt_o  = rst ? '0 : jump_cnt;
    assign cu_stall_cnt_o = rst ? '0 : stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Testbench for pipe_ctrl_unit. Two instances (FLUSH_CYCLES = 1 and 3) share
// one stimulus stream; a per-instance behavioural model predicts every output
// each cycle, and a directed prologue pins the model with literal values.

module tb_pipe_ctrl_unit;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic       clk = 1'b0;
    logic       rst;
    logic       jump;
    logic [6:0] opc;
    logic [4:0] rd, rs1, rs2;
    logic       hreq;

    logic [1:0] a_jump, a_pch, a_ifh, a_iff, a_xf, a_wb, a_busy;
`ifdef CU_PERF_CNT_EN
    logic [31:0] a_jc [2];
    logic [31:0] a_sc [2];
`endif

    int checks = 0;
    int errors = 0;

    // behavioural model state, one slot per instance
    int unsigned fc [2] = '{1, 3};
    bit          m_id [2];
    bit          m_ex [2];
    int          m_fl [2];   // flush cycles still owed after the current one
    logic [31:0] m_jc [2];
    logic [31:0] m_sc [2];

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.FLUSH_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .ex2cu_jump_en_i(jump), .idex2cu_opcode_i(opc), .idex2cu_rd_addr_i(rd),
        .ifid2cu_rs1_i(rs1), .ifid2cu_rs2_i(rs2), .bus2cu_hold_req_i(hreq),
        .cu2pc_jump_en_o(a_jump[0]), .cu2pc_hold_o(a_pch[0]), .cu2ifid_hold_o(a_ifh[0]),
        .cu2ifid_flush_o(a_iff[0]), .cu2idex_flush_o(a_xf[0]), .cu2ex_wb_en_o(a_wb[0]),
        .cu_busy_o(a_busy[0])
`ifdef CU_PERF_CNT_EN
        , .cu_jump_cnt_o(a_jc[0]), .cu_stall_cnt_o(a_sc[0])
`endif
    );

    pipe_ctrl_unit #(.FLUSH_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .ex2cu_jump_en_i(jump), .idex2cu_opcode_i(opc), .idex2cu_rd_addr_i(rd),
        .ifid2cu_rs1_i(rs1), .ifid2cu_rs2_i(rs2), .bus2cu_hold_req_i(hreq),
        .cu2pc_jump_en_o(a_jump[1]), .cu2pc_hold_o(a_pch[1]), .cu2ifid_hold_o(a_ifh[1]),
        .cu2ifid_flush_o(a_iff[1]), .cu2idex_flush_o(a_xf[1]), .cu2ex_wb_en_o(a_wb[1]),
        .cu_busy_o(a_busy[1])
`ifdef CU_PERF_CNT_EN
        , .cu_jump_cnt_o(a_jc[1]), .cu_stall_cnt_o(a_sc[1])
`endif
    );

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    // Compare every output of both instances against the model, then advance
    // the model across the coming clock edge.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit busy, jt, lu, st, ff, wb;
            busy = (m_fl[k] > 0);
            jt   = !rst && jump && m_ex[k] && !busy;
            lu   = m_ex[k] && m_id[k] && (opc == OP_LOAD) && (rd != 0) && (rd == rs1 || rd == rs2);
            st   = !rst && !jt && !busy && (hreq || lu);
            ff   = !rst && (jt || busy);
            wb   = !rst && m_ex[k] && (opc != OP_STORE) && (opc != OP_BRANCH) && (opc != 0) && (rd != 0);

            chk("jump_en",    k, 32'(a_jump[k]), 32'(jt));
            chk("pc_hold",    k, 32'(a_pch[k]),  32'(st));
            chk("ifid_hold",  k, 32'(a_ifh[k]),  32'(st));
            chk("ifid_flush", k, 32'(a_iff[k]),  32'(ff));
            chk("idex_flush", k, 32'(a_xf[k]),   32'(ff || st));
            chk("wb_en",      k, 32'(a_wb[k]),   32'(wb));
            chk("busy",       k, 32'(a_busy[k]), 32'(!rst && busy));
`ifdef CU_PERF_CNT_EN
            chk("jump_cnt",   k, a_jc[k], rst ? 32'd0 : m_jc[k]);
            chk("stall_cnt",  k, a_sc[k], rst ? 32'd0 : m_sc[k]);
`endif
            if (rst) begin
                m_id[k] = 0; m_ex[k] = 0; m_fl[k] = 0; m_jc[k] = '0; m_sc[k] = '0;
            end else begin
                m_ex[k] = ff || st ? 1'b0 : m_id[k];
                m_id[k] = ff ? 1'b0 : (st ? m_id[k] : 1'b1);
                if (jt)        m_fl[k] = int'(fc[k]) - 1;
                else if (busy) m_fl[k] = m_fl[k] - 1;
                if (jt) m_jc[k] = m_jc[k] + 32'd1;
                if (st) m_sc[k] = m_sc[k] + 32'd1;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic j, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic h);
        @(negedge clk);
        rst = r; jump = j; opc = op; rd = d; rs1 = s1; rs2 = s2; hreq = h;
        #1;
        model_step();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_id[k] = 0; m_ex[k] = 0; m_fl[k] = 0; m_jc[k] = '0; m_sc[k] = '0;
        end
        rst = 1'b1; jump = 1'b0; opc = OP_ADDI; rd = 5'd5; rs1 = 5'd1; rs2 = 5'd1; hreq = 1'b0;

        // reset: everything low
        cyc(1, 0, OP_ADDI, 5, 1, 1, 0);
        cyc(1, 1, OP_ADDI, 5, 1, 1, 1);
        chk("rst_pc_hold", 0, 32'(a_pch[0]), 32'd0);
        chk("rst_jump",    1, 32'(a_jump[1]), 32'd0);

        // cycles 0..2 after release: ADDI rd=5 becomes valid in EX at cycle 2
        cyc(0, 0, OP_ADDI, 5, 1, 1, 0);
        chk("c0_wb", 0, 32'(a_wb[0]), 32'd0);
        cyc(0, 0, OP_ADDI, 5, 1, 1, 0);
        cyc(0, 0, OP_ADDI, 5, 1, 1, 0);
        chk("c2_wb", 0, 32'(a_wb[0]), 32'd1);

        // cycle 3: jump, rd=0 -> no wb
        cyc(0, 1, OP_ADDI, 0, 1, 1, 0);
        chk("c3_jump",  0, 32'(a_jump[0]), 32'd1);
        chk("c3_iff",   0, 32'(a_iff[0]),  32'd1);
        chk("c3_xf",    1, 32'(a_xf[1]),   32'd1);
        chk("c3_wb",    0, 32'(a_wb[0]),   32'd0);
        // cycle 4: jump request from a bubble / during flush is ignored
        cyc(0, 1, OP_ADDI, 5, 1, 1, 0);
        chk("c4_jump1", 0, 32'(a_jump[0]), 32'd0);
        chk("c4_iff1",  0, 32'(a_iff[0]),  32'd0);
        chk("c4_jump3", 1, 32'(a_jump[1]), 32'd0);
        chk("c4_busy3", 1, 32'(a_busy[1]), 32'd1);
        chk("c4_iff3",  1, 32'(a_iff[1]),  32'd1);
        cyc(0, 0, OP_ADDI, 5, 1, 1, 0);
        chk("c5_busy3", 1, 32'(a_busy[1]), 32'd1);
        cyc(0, 0, OP_ADDI, 5, 1, 1, 0);
        chk("c6_busy3", 1, 32'(a_busy[1]), 32'd0);
        chk("c6_iff3",  1, 32'(a_iff[1]),  32'd0);
        cyc(0, 0, OP_ADDI, 5, 1, 1, 0);

        // cycle 8: load rd=7, ID rs2=7 -> one-cycle stall
        cyc(0, 0, OP_LOAD, 7, 1, 7, 0);
        chk("c8_pch", 0, 32'(a_pch[0]), 32'd1);
        chk("c8_ifh", 1, 32'(a_ifh[1]), 32'd1);
        chk("c8_xf",  0, 32'(a_xf[0]),  32'd1);
        cyc(0, 0, OP_LOAD, 7, 1, 7, 0);
        chk("c9_wb",  0, 32'(a_wb[0]),  32'd0);
        chk("c9_pch", 0, 32'(a_pch[0]), 32'd0);
        cyc(0, 0, OP_LOAD, 0, 0, 0, 0);
        chk("c10_pch", 1, 32'(a_pch[1]), 32'd0);

        // cycles 11..14: bus hold, jump in the first hold cycle
        cyc(0, 1, OP_ADDI, 5, 1, 1, 1);
        chk("c11_jump", 0, 32'(a_jump[0]), 32'd1);
        chk("c11_pch",  0, 32'(a_pch[0]),  32'd0);
        chk("c11_iff",  0, 32'(a_iff[0]),  32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, OP_ADDI, 5, 1, 1, 1);
            chk("hold_pch", 0, 32'(a_pch[0]), 32'd1);
`ifdef CU_PERF_CNT_EN
            if (i == 0) begin
                chk("perf_jc", 0, a_jc[0], 32'd2);
                chk("perf_sc", 0, a_sc[0], 32'd1);
            end
`endif
        end
        cyc(0, 0, OP_ADDI, 5, 1, 1, 0);
        cyc(1, 0, OP_ADDI, 5, 1, 1, 0);
        cyc(0, 0, OP_ADDI, 5, 1, 1, 0);
`ifdef CU_PERF_CNT_EN
        chk("perf_jc_rst", 0, a_jc[0], 32'd0);
        chk("perf_sc_rst", 1, a_sc[1], 32'd0);
`endif

        // randomized phase
        for (int n = 0; n < 4000; n++) begin
            logic [6:0] op;
            case ($urandom_range(0, 7))
                0, 1, 2: op = OP_LOAD;
                3:       op = OP_STORE;
                4:       op = OP_BRANCH;
                5:       op = 7'b0;
                6:       op = OP_JAL;
                default: op = OP_ADDI;
            endcase
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 30), op,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 99) < 15));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
